// File: rtl/instr_fetch_queue_pkg.sv
// Shared types for the instruction fetch queue: FSM states, FIFO entry layout,
// and the word-alignment helper used for every fetch address.
package instr_fetch_queue_pkg;

  localparam int unsigned INSTR_W          = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] word;
  } fetch_entry_t;

  function automatic logic [31:0] wordAlign(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_queue_fifo.sv
// Synchronous FIFO of {pc, word} entries. Flush has priority over push and pop,
// and a push into a full queue is accepted only when a pop frees a slot that cycle.
module instr_fetch_queue_fifo
  import instr_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  fetch_entry_t                 pushData_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o,
  output logic                         full_o,
  output fetch_entry_t                 head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t       entries_q [DEPTH];
  logic [PTR_W-1:0]   rdPtr_q;
  logic [PTR_W-1:0]   wrPtr_q;
  logic [CNT_W-1:0]   count_q;
  logic               doPush;
  logic               doPop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = entries_q[rdPtr_q];

  assign doPop  = pop_i && !empty_o && !flush_i;
  assign doPush = push_i && !flush_i && (!full_o || doPop);

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(doPush) - CNT_W'(doPop);
    end
  end

  // Storage carries no reset; validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (doPush) entries_q[wrPtr_q] <= pushData_i;
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front-end: owns the fetch PC, keeps one memory read in flight, and
// queues returned words with their PCs for decode. Redirect flushes and restarts.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_state_e      state_q, state_d;
  logic [31:0]       fetchPc_q, fetchPc_d;
  logic [31:0]       reqPc_q, reqPc_d;
  logic              reqHs;
  logic              fifoPush;
  logic              fifoEmpty;
  logic              fifoFull;
  logic [CNT_W-1:0]  fifoCount;
  fetch_entry_t      fifoHead;

  // Held low while reset is asserted so nothing is requested before state is known.
  assign mem_req_valid = (state_q == IDLE) && (fifoCount < CNT_W'(DEPTH)) && !reset;
  assign mem_req_addr  = fetchPc_q;
  assign reqHs         = mem_req_valid && mem_req_ready;

  assign instr_valid = !fifoEmpty;
  assign instr       = fifoHead.word;
  assign instr_pc    = fifoHead.pc;

  always_comb begin
    state_d   = state_q;
    fetchPc_d = fetchPc_q;
    reqPc_d   = reqPc_q;
    fifoPush  = 1'b0;
    case (state_q)
      IDLE: begin
        if (reqHs) begin
          reqPc_d   = fetchPc_q;
          fetchPc_d = fetchPc_q + 32'd4;
          state_d   = redirect ? DROP : WAIT;
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          fifoPush = !redirect && !fifoFull;
          state_d  = IDLE;
        end else if (redirect) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (mem_resp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A redirect overrides any +4 advance from a same-cycle handshake.
    if (redirect) fetchPc_d = wordAlign(redirect_pc);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      fetchPc_q <= wordAlign(RESET_PC);
      reqPc_q   <= '0;
    end else begin
      state_q   <= state_d;
      fetchPc_q <= fetchPc_d;
      reqPc_q   <= reqPc_d;
    end
  end

  instr_fetch_queue_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (fifoPush),
    .pushData_i ({reqPc_q, mem_resp_data}),
    .pop_i      (instr_ready),
    .flush_i    (redirect),
    .count_o    (fifoCount),
    .empty_o    (fifoEmpty),
    .full_o     (fifoFull),
    .head_o     (fifoHead)
  );

endmodule
